line_render_engine: RTL and testbench

//  Consumes decoded ops (start, end1, color, op, received_op, flip_buffer) from the command decoder.

---
 rtl/line_render_engine_pkg.sv | 32 +++
 rtl/line_render_engine_if.sv | 28 ++
 rtl/line_render_engine_stepper.sv | 82 ++++++++
 rtl/line_render_engine.sv | 127 ++++++++++++
 tb/tb_line_render_engine.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/line_render_engine_pkg.sv
// Shared types and constants for the line render engine: opcodes, screen geometry,
// the coordinate payload and the render FSM state encoding.
package line_render_engine_pkg;

  localparam int unsigned H_RES  = 320;
  localparam int unsigned V_RES  = 240;
  localparam int unsigned X_W    = 9;
  localparam int unsigned Y_W    = 8;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned COLOR_W = 32;
  localparam int unsigned D_W    = 11;
  localparam int unsigned NPIX   = H_RES * V_RES;

  localparam logic [2:0] OP_CLEAR = 3'b000;
  localparam logic [2:0] OP_DRAW  = 3'b110;
  localparam logic [2:0] OP_FLIP  = 3'b111;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PLOT,
    ST_STEP,
    ST_CLR_PLOT
  } render_state_t;

endpackage

// File: rtl/line_render_engine_if.sv
// Decoder-side op inputs and SRAM-side pixel write port of the render engine.
interface line_render_engine_if;
  import line_render_engine_pkg::*;

  coord_t              start;
  coord_t              end1;
  logic [COLOR_W-1:0]  color;
  logic [2:0]          op;
  logic                received_op;
  logic                flip_buffer;
  logic                pixel_ready;
  logic                render_enable;
  logic                pixel_wr;
  logic [ADDR_W-1:0]   pixel_addr;
  logic [DATA_W-1:0]   pixel_data;
  logic                back_buffer;

  modport slave (
    input  start, end1, color, op, received_op, flip_buffer, pixel_ready,
    output render_enable, pixel_wr, pixel_addr, pixel_data, back_buffer
  );

  modport master (
    output start, end1, color, op, received_op, flip_buffer, pixel_ready,
    input  render_enable, pixel_wr, pixel_addr, pixel_data, back_buffer
  );

endinterface

// File: rtl/line_render_engine_stepper.sv
// Bresenham datapath: loads deltas/direction/error on i_load, advances one point on i_step,
// and flags when the current point equals the line end point.
module line_stepper
  import line_render_engine_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic           i_step,
  input  coord_t         i_start,
  input  coord_t         i_end,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_at_end
);

  logic [X_W-1:0]        r_x;
  logic [Y_W-1:0]        r_y;
  logic signed [D_W-1:0] r_dx;
  logic signed [D_W-1:0] r_dy;
  logic signed [D_W-1:0] r_err;
  logic                  r_sx_neg;
  logic                  r_sy_neg;

  logic signed [D_W-1:0] w_dx_raw;
  logic signed [D_W-1:0] w_dy_raw;
  logic signed [D_W-1:0] w_dx_abs;
  logic signed [D_W-1:0] w_dy_nabs;
  logic signed [D_W:0]   w_e2;
  logic signed [D_W:0]   w_dx12;
  logic signed [D_W:0]   w_dy12;
  logic                  w_x_move;
  logic                  w_y_move;
  logic signed [D_W-1:0] w_err_nxt;

  // Setup arithmetic on zero-extended endpoints
  always_comb begin
    w_dx_raw  = $signed({2'b00, i_end.x}) - $signed({2'b00, i_start.x});
    w_dy_raw  = $signed({3'b000, i_end.y}) - $signed({3'b000, i_start.y});
    w_dx_abs  = w_dx_raw[D_W-1] ? -w_dx_raw : w_dx_raw;
    w_dy_nabs = w_dy_raw[D_W-1] ? w_dy_raw : -w_dy_raw;
  end

  // Both step decisions use the pre-step error term
  always_comb begin
    w_e2      = {r_err, 1'b0};
    w_dx12    = {r_dx[D_W-1], r_dx};
    w_dy12    = {r_dy[D_W-1], r_dy};
    w_x_move  = (w_e2 >= w_dy12);
    w_y_move  = (w_e2 <= w_dx12);
    w_err_nxt = r_err + (w_x_move ? r_dy : D_W'(0)) + (w_y_move ? r_dx : D_W'(0));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else if (i_load) begin
      r_x      <= i_start.x;
      r_y      <= i_start.y;
      r_dx     <= w_dx_abs;
      r_dy     <= w_dy_nabs;
      r_err    <= w_dx_abs + w_dy_nabs;
      r_sx_neg <= !(i_start.x < i_end.x);
      r_sy_neg <= !(i_start.y < i_end.y);
    end else if (i_step) begin
      r_err <= w_err_nxt;
      if (w_x_move) r_x <= r_sx_neg ? r_x - X_W'(1) : r_x + X_W'(1);
      if (w_y_move) r_y <= r_sy_neg ? r_y - Y_W'(1) : r_y + Y_W'(1);
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_at_end = (r_x == i_end.x) && (r_y == i_end.y);

endmodule

// File: rtl/line_render_engine.sv
// Line/clear render engine: op acceptance FSM, clipping, address generation,
// pixel write handshake and double-buffer selection around the Bresenham stepper.
module line_render_engine
  import line_render_engine_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  line_render_engine_if.slave  io_bus
);

  render_state_t      r_state;
  render_state_t      w_next;
  coord_t             r_start;
  coord_t             r_end;
  logic [DATA_W-1:0]  r_color;
  logic [ADDR_W-1:0]  r_clr_addr;
  logic               r_back;
  logic               r_flip_pend;

  logic               w_accept;
  logic               w_load;
  logic               w_step;
  logic               w_clr_inc;
  logic [X_W-1:0]     w_x;
  logic [Y_W-1:0]     w_y;
  logic               w_at_end;
  logic               w_on_screen;
  logic [ADDR_W-1:0]  w_draw_addr;
  logic [7:0]         w_unused_color_hi;

  assign w_unused_color_hi = io_bus.color[COLOR_W-1:DATA_W];

  line_stepper u_stepper (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_start  (r_start),
    .i_end    (r_end),
    .o_x      (w_x),
    .o_y      (w_y),
    .o_at_end (w_at_end)
  );

  assign w_on_screen = (w_x < X_W'(H_RES)) && (w_y < Y_W'(V_RES));
  // y*320 + x as shift-and-add
  assign w_draw_addr = (ADDR_W'(w_y) << 8) + (ADDR_W'(w_y) << 6) + ADDR_W'(w_x);

  // Next-state and control strobes
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_clr_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_bus.received_op && (io_bus.op == OP_DRAW)) begin
          w_accept = 1'b1;
          w_next   = ST_SETUP;
        end else if (io_bus.received_op && (io_bus.op == OP_CLEAR)) begin
          w_accept = 1'b1;
          w_next   = ST_CLR_PLOT;
        end
      end
      ST_SETUP: begin
        w_load = 1'b1;
        w_next = ST_PLOT;
      end
      ST_PLOT: begin
        // Off-screen points skip the handshake but are still walked
        if (!w_on_screen || io_bus.pixel_ready) begin
          w_next = w_at_end ? ST_IDLE : ST_STEP;
        end
      end
      ST_STEP: begin
        w_step = 1'b1;
        w_next = ST_PLOT;
      end
      ST_CLR_PLOT: begin
        if (io_bus.pixel_ready) begin
          if (r_clr_addr == ADDR_W'(NPIX - 1)) w_next = ST_IDLE;
          else                                 w_clr_inc = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_start     <= '0;
      r_end       <= '0;
      r_color     <= '0;
      r_clr_addr  <= '0;
      r_back      <= 1'b0;
      r_flip_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_start    <= io_bus.start;
        r_end      <= io_bus.end1;
        r_color    <= io_bus.color[DATA_W-1:0];
        r_clr_addr <= '0;
      end else if (w_clr_inc) begin
        r_clr_addr <= r_clr_addr + ADDR_W'(1);
      end
      // Flips while busy are held (and merged) until the edge that returns to IDLE
      if (r_state == ST_IDLE) begin
        if (io_bus.flip_buffer) r_back <= ~r_back;
      end else if (w_next == ST_IDLE) begin
        r_back      <= r_back ^ (r_flip_pend | io_bus.flip_buffer);
        r_flip_pend <= 1'b0;
      end else if (io_bus.flip_buffer) begin
        r_flip_pend <= 1'b1;
      end
    end
  end

  assign io_bus.render_enable = (r_state != ST_IDLE);
  assign io_bus.pixel_wr      = ((r_state == ST_PLOT) && w_on_screen) || (r_state == ST_CLR_PLOT);
  assign io_bus.pixel_addr    = (r_state == ST_CLR_PLOT) ? r_clr_addr : w_draw_addr;
  assign io_bus.pixel_data    = r_color;
  assign io_bus.back_buffer   = r_back;

endmodule

// File: tb/tb_line_render_engine.sv
// Scoreboard bench for line_render_engine: directed ops push expected writes,
// a negedge monitor pops and compares every accepted pixel write.
module tb_line_render_engine;
  import line_render_engine_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  wr_t  exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_writes = 0;
  logic exp_bb = 1'b0;
  int   cyc;

  line_render_engine_if bus ();

  line_render_engine dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted write must match the head of the queue
  always @(negedge clk) begin
    if (bus.pixel_wr && bus.pixel_ready) begin
      n_writes++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_write: got addr %0d data %06h, expected no write",
                 bus.pixel_addr, bus.pixel_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.pixel_addr !== e.addr || bus.pixel_data !== e.data) begin
          n_mis++;
          $display("FAIL pixel_write: got addr %0d data %06h, expected addr %0d data %06h",
                   bus.pixel_addr, bus.pixel_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int addr, input logic [23:0] data);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input int x0, input int y0, input int x1,
                       input int y1, input logic [31:0] col, input logic flip);
    bus.op          = op;
    bus.start       = {X_W'(x0), Y_W'(y0)};
    bus.end1        = {X_W'(x1), Y_W'(y1)};
    bus.color       = col;
    bus.received_op = 1'b1;
    bus.flip_buffer = flip;
    tick();
    bus.received_op = 1'b0;
    bus.flip_buffer = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (bus.render_enable && cycles < budget) begin
      tick();
      cycles++;
    end
    check("idle_reached", int'(bus.render_enable), 0);
  endtask

  initial begin
    int a_diag[4];
    int a_steep[4];
    a_diag  = '{1605, 1284, 963, 642};
    a_steep = '{0, 320, 641, 961};

    rst = 1'b1;
    bus.op = 3'b0; bus.start = '0; bus.end1 = '0; bus.color = '0;
    bus.received_op = 1'b0; bus.flip_buffer = 1'b0; bus.pixel_ready = 1'b1;
    tick(); tick();
    check("rst_render_enable", int'(bus.render_enable), 0);
    check("rst_pixel_wr", int'(bus.pixel_wr), 0);
    check("rst_pixel_addr", int'(bus.pixel_addr), 0);
    check("rst_pixel_data", int'(bus.pixel_data), 0);
    check("rst_back_buffer", int'(bus.back_buffer), 0);
    rst = 1'b0;
    tick();

    // Flip in IDLE toggles on the next edge
    bus.flip_buffer = 1'b1; tick(); bus.flip_buffer = 1'b0;
    exp_bb = ~exp_bb;
    check("idle_flip", int'(bus.back_buffer), int'(exp_bb));

    // Non-render ops are ignored
    issue(OP_FLIP, 0, 0, 3, 0, 32'h0, 1'b0);
    check("ignored_op", int'(bus.render_enable), 0);

    // Horizontal line, upper colour byte ignored
    for (int i = 0; i < 4; i++) push(i, 24'h00FF00);
    n_writes = 0;
    issue(OP_DRAW, 0, 0, 3, 0, 32'hAB00FF00, 1'b0);
    check("horiz_enable_n1", int'(bus.render_enable), 1);
    wait_idle(50, cyc);
    check("horiz_busy_cycles", cyc, 8);
    check("horiz_writes", n_writes, 4);

    // Diagonal and steep lines
    foreach (a_diag[i]) push(a_diag[i], 24'h123456);
    issue(OP_DRAW, 5, 5, 2, 2, 32'h00123456, 1'b0);
    wait_idle(50, cyc);
    foreach (a_steep[i]) push(a_steep[i], 24'hABCDEF);
    n_writes = 0;
    issue(OP_DRAW, 0, 0, 1, 3, 32'h00ABCDEF, 1'b0);
    wait_idle(50, cyc);
    check("steep_writes", n_writes, 4);
    check("q_empty_lines", exp_q.size(), 0);

    // Backpressure on first write: request held stable, no duplicates
    for (int i = 0; i < 3; i++) push(3210 + i, 24'h0000AA);
    n_writes = 0;
    bus.pixel_ready = 1'b0;
    issue(OP_DRAW, 10, 10, 12, 10, 32'h000000AA, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_wr", int'(bus.pixel_wr), 1);
      check("bp_addr", int'(bus.pixel_addr), 3210);
      check("bp_data", int'(bus.pixel_data), 32'h0000AA);
      tick();
    end
    bus.pixel_ready = 1'b1;
    wait_idle(50, cyc);
    check("bp_writes", n_writes, 3);

    // Flip pulses mid-draw are held and merged into one toggle at IDLE entry
    for (int i = 0; i < 4; i++) push(i, 24'h00FF00);
    issue(OP_DRAW, 0, 0, 3, 0, 32'h0000FF00, 1'b0);
    tick();
    bus.flip_buffer = 1'b1; tick(); bus.flip_buffer = 1'b0;
    check("pend_bb_hold1", int'(bus.back_buffer), int'(exp_bb));
    bus.flip_buffer = 1'b1; tick(); bus.flip_buffer = 1'b0;
    check("pend_bb_hold2", int'(bus.back_buffer), int'(exp_bb));
    wait_idle(50, cyc);
    exp_bb = ~exp_bb;
    check("pend_bb_applied", int'(bus.back_buffer), int'(exp_bb));
    tick(); tick();
    check("pend_bb_once", int'(bus.back_buffer), int'(exp_bb));

    // Degenerate point together with a flip in IDLE
    push(2247, 24'h777777);
    n_writes = 0;
    issue(OP_DRAW, 7, 7, 7, 7, 32'h00777777, 1'b1);
    exp_bb = ~exp_bb;
    check("sim_flip_bb", int'(bus.back_buffer), int'(exp_bb));
    wait_idle(50, cyc);
    check("point_writes", n_writes, 1);

    // Clipped line with off-screen end point
    push(318, 24'h0F0F0F);
    push(319, 24'h0F0F0F);
    n_writes = 0;
    issue(OP_DRAW, 318, 0, 322, 0, 32'h000F0F0F, 1'b0);
    wait_idle(50, cyc);
    check("clip_writes", n_writes, 2);
    check("q_empty_clip", exp_q.size(), 0);

    // Full-screen clear
    for (int i = 0; i < int'(NPIX); i++) push(i, 24'h000FFF);
    n_writes = 0;
    issue(OP_CLEAR, 0, 0, 0, 0, 32'hFF000FFF, 1'b0);
    wait_idle(int'(NPIX) + 100, cyc);
    check("clear_busy_cycles", cyc, int'(NPIX));
    check("clear_writes", n_writes, int'(NPIX));

    // Reset in the middle of a clear
    for (int i = 0; i < 6; i++) push(i, 24'h555555);
    issue(OP_CLEAR, 0, 0, 0, 0, 32'h00555555, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check("midrst_pixel_wr", int'(bus.pixel_wr), 0);
    check("midrst_render_enable", int'(bus.render_enable), 0);
    check("midrst_back_buffer", int'(bus.back_buffer), 0);
    rst = 1'b0;
    tick(); tick();
    check("q_empty_final", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
